// File: rtl/al_clk_pkg.sv
// Shared types and constants for the alarm-clock key-entry controller.
package al_clk_pkg;

    localparam int unsigned KEY_W     = 4;
    localparam int unsigned TIMEOUT_W = 4;
    localparam logic [KEY_W-1:0] NOKEY = 4'd10;

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM
    } state_t;

    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/al_clk_timeout.sv
// Saturating seconds counter that aborts key entry after TIMEOUT_SECS idle strobes.
module al_clk_timeout
    import al_clk_pkg::*;
#(
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_SECS - 1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && tick && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && tick && (count == LAST);

endmodule

// File: rtl/al_clk_controller.sv
// Key-entry / alarm-display controller for the alarm clock.
module al_clk_controller
    import al_clk_pkg::*;
#(
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_second,
    input  logic [KEY_W-1:0] key,
    input  logic             alarm_button,
    input  logic             time_button,
    output logic             shift,
    output logic             show_new_time,
    output logic             show_a,
    output logic             load_new_a,
    output logic             load_new_c
);

    state_t state, next_state;
    logic   digit, no_key;
    logic   to_clear, to_en, expired;
    logic   load_a_d, load_c_d;

    assign digit  = is_digit(key);
    assign no_key = (key >= NOKEY);

    al_clk_timeout #(.TIMEOUT_SECS(TIMEOUT_SECS)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (to_clear),
        .tick    (one_second),
        .en      (to_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SHOW_TIME;
            load_new_a <= 1'b0;
            load_new_c <= 1'b0;
        end else begin
            state      <= next_state;
            load_new_a <= load_a_d;
            load_new_c <= load_c_d;
        end
    end

    always_comb begin
        next_state = state;
        load_a_d   = 1'b0;
        load_c_d   = 1'b0;
        unique case (state)
            SHOW_TIME: begin
                if (alarm_button)  next_state = SHOW_ALARM;
                else if (digit)    next_state = KEY_STORED;
            end
            KEY_STORED: next_state = KEY_WAITED;
            KEY_WAITED: begin
                if (no_key)        next_state = KEY_ENTRY;
                else if (expired)  next_state = SHOW_TIME;
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    next_state = SHOW_TIME;
                    load_a_d   = 1'b1;
                end else if (time_button) begin
                    next_state = SHOW_TIME;
                    load_c_d   = 1'b1;
                end else if (digit) begin
                    next_state = KEY_STORED;
                end else if (expired) begin
                    next_state = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) next_state = SHOW_TIME;
            end
            default: next_state = SHOW_TIME;
        endcase
    end

    // Clearing on the next-state decode covers both "entering KEY_STORED" and
    // "reaching SHOW_TIME"; a digit coincident with a strobe therefore clears.
    assign to_clear = (next_state == KEY_STORED) || (next_state == SHOW_TIME);
    assign to_en    = (state == KEY_WAITED) || (state == KEY_ENTRY);

    assign shift         = (state == KEY_STORED);
    assign show_new_time = (state == KEY_STORED) || (state == KEY_WAITED) || (state == KEY_ENTRY);
    assign show_a        = (state == SHOW_ALARM);

endmodule
